led_panel_bcm: RTL
==================

Name: led_panel_bcm

Overview:
- Parametrised successor to the single-bit LED panel driver.
- Drives a HUB75-style panel: two half-panels scanned in parallel, one shared row address, serial column shift with latch and blank.
- Adds multi-bit colour through binary-coded modulation (BCM) and a double-buffered frame store with a synchronous write port.
- Sits between the UART byte/command decoder, which drives the write and swap ports, and the panel pins.

Parameters:
- COLS, 8: columns per row; must be a power of two and ≥ 2.
- ROW_ADDR_BITS, 2: scan address width; scan rows = 2^ROW_ADDR_BITS; panel rows = 2^(ROW_ADDR_BITS+1).
- BPC, 2: bits per colour channel; also the number of BCM planes.
- BASE_TICKS, 4: display clocks for plane 0; plane p displays BASE_TICKS<<p clocks.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe into back buffer
- wr_addr  in  ROW_ADDR_BITS+1+log2(COLS)  {row, col}
- wr_data  in  3*BPC  {r[BPC-1:0], g, b}
- swap_req  in  1  pulse; request a buffer swap at frame end
- swap_done  out  1  one-cycle pulse when the swap takes effect
- red_out  out  2  [0] upper half-panel bit, [1] lower half-panel bit
- green_out  out  2  same packing as red_out
- blue_out  out  2  same packing as red_out
- sclk_out  out  1  column shift clock
- latch_out  out  1  row latch
- blank_out  out  1  1 = LEDs off
- addr_out  out  ROW_ADDR_BITS  scan row address (replaces discrete a/b pins)

Behaviour:
- Reset: both buffers cleared to 0; front = buffer 0; row = 0; plane = 0; FSM = SHIFT, column 0.
- Output reset values: colour outputs 0, sclk_out 0, latch_out 0, blank_out 1, addr_out 0, swap_done 0.
- Reset mid-operation: returns to this state on the next edge; a pending swap is cleared.
- FSM SHIFT: 2 clocks per column, blank_out = 1.
  - Phase 0: present column c data, sclk_out = 0.
  - Phase 1: data held, sclk_out = 1.
  - Upper half data = front[row][c] bit `plane`; lower half data = front[row + 2^ROW_ADDR_BITS][c] bit `plane`.
  - After column COLS-1 phase 1 → LATCH.
- FSM LATCH: 1 clock, latch_out = 1, blank_out = 1, sclk_out = 0, addr_out updated to row.
  - Next state: DISPLAY.
- FSM DISPLAY: blank_out = 0 for exactly BASE_TICKS<<plane clocks; latch_out = 0; colour outputs held.
  - Then SHIFT with plane+1.
  - If plane was BPC-1: plane = 0, row+1.
  - If row was the last scan row: row wraps to 0 at frame end.
- Clocks per row per plane = 2*COLS + 1 + (BASE_TICKS<<plane).
- Write port:
  - wr_en writes the back buffer only, in the same cycle; never visible before a swap.
  - Row field ≥ 2^(ROW_ADDR_BITS+1) cannot occur (full width); no out-of-range case.
- Swap:
  - swap_req sets a pending flag.
  - At frame end (last clock of DISPLAY, plane BPC-1, last row), pending → front toggles, swap_done pulses that cycle, pending clears.
  - swap_req arriving in the frame-end cycle is honoured in that same cycle.
  - Multiple requests in one frame give one swap.
- Write and swap in the same cycle: the write lands in the old back buffer, which becomes the new front.

Optional Feature:
- Macro LED_PANEL_TEST_PATTERN_EN.
- Defined: adds input `mode` (1 bit).
  - mode = 1: SHIFT data is a generated pattern instead of buffer contents.
  - Pattern: red = col[0], green = row[0], blue = plane[0], identical for both halves.
  - Timing unchanged; swap and write still operate.
- Undefined: no mode port; data always from the front buffer.

Decomposition:
- Package led_panel_pkg:
  - FSM state enum {SHIFT, LATCH, DISPLAY}.
  - Pixel packing widths and field offsets (R/G/B slices).
  - Address-width helper function.
- One sub-module, led_panel_fb: dual-bank register frame store with write port, two combinational read ports (upper/lower row) and a bank-select input.

Test Plan:
- Reset, no writes, defaults → blank_out = 1 for 17 clocks (16 SHIFT + 1 LATCH); 8 sclk_out rising edges; all colour outputs 0; then blank_out = 0 for 4 clocks.
- Write pixel {row 0, col 3} = r = 3, swap_req → swap_done once at frame end; next frame plane 0 and plane 1: red_out[0] = 1 only during column 3 shift; red_out[1] = 0.
- Write {row 4, col 0} = g = 2, swap → green_out[1] = 1 in plane 1 only, addr_out = 0; row 4 shows on the lower half.
- Measure DISPLAY lengths across one row → 4 then 8 clocks; addr_out sequence 0,1,2,3,0 each after LATCH; frame = 4 rows × (17+4 + 17+8) = 184 clocks.
- Three swap_req pulses in one frame plus a write during the frame-end cycle → exactly one swap_done; the written pixel appears in the following frame.
- Assert reset mid-DISPLAY on row 2 → next cycle blank_out = 1, addr_out = 0, pending swap dropped, front = bank 0.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared FSM state type, pixel packing offsets and width helpers for the
// BCM LED panel driver.
package led_panel_pkg;

   typedef enum logic [1:0] {
      ST_SHIFT   = 2'd0,
      ST_LATCH   = 2'd1,
      ST_DISPLAY = 2'd2
   } state_t;

   localparam int NUM_CHAN = 3;
   localparam int BLUE_LO  = 0;

   // Pixel word is {r, g, b}, each channel bpc bits wide.
   function automatic int pix_width(input int bpc);
      return NUM_CHAN * bpc;
   endfunction

   function automatic int red_lo(input int bpc);
      return 2 * bpc;
   endfunction

   function automatic int green_lo(input int bpc);
      return bpc;
   endfunction

   function automatic int addr_width(input int row_addr_bits, input int cols);
      return row_addr_bits + 1 + $clog2(cols);
   endfunction

endpackage

// File: rtl/led_panel_fb.sv
// Dual-bank register frame store: synchronous write into the back bank,
// combinational reads of the upper and lower half-panel rows from the front bank.
module led_panel_fb
   import led_panel_pkg::*;
#(
   parameter int COLS          = 8,
   parameter int ROW_ADDR_BITS = 2,
   parameter int BPC           = 2,
   localparam int AW           = addr_width(ROW_ADDR_BITS, COLS),
   localparam int PW           = pix_width(BPC),
   localparam int CW           = $clog2(COLS)
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_wr_en,
   input  logic [AW-1:0]            i_wr_addr,
   input  logic [PW-1:0]            i_wr_data,
   input  logic                     i_front,
   input  logic [ROW_ADDR_BITS-1:0] i_rd_row,
   input  logic [CW-1:0]            i_rd_col,
   output logic [PW-1:0]            o_upper,
   output logic [PW-1:0]            o_lower
);

   localparam int DEPTH = 1 << AW;

   logic [PW-1:0] r_mem [2][DEPTH];

   // The back bank is always the one not selected for display, so a write
   // coinciding with a swap lands in the bank that is about to become front.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_mem[b][i] <= '0;
            end
         end
      end else if (i_wr_en) begin
         r_mem[!i_front][i_wr_addr] <= i_wr_data;
      end
   end

   assign o_upper = r_mem[i_front][{1'b0, i_rd_row, i_rd_col}];
   assign o_lower = r_mem[i_front][{1'b1, i_rd_row, i_rd_col}];

endmodule

// File: rtl/led_panel_bcm.sv
// HUB75-style panel driver with binary-coded modulation and a double-buffered
// frame store. Optional LED_PANEL_TEST_PATTERN_EN adds i_mode for a built-in pattern.
//
// state      | meaning
// ST_SHIFT   | clock out one row of one bit-plane, 2 clocks per column, blanked
// ST_LATCH   | 1 clock: latch shifted row, update scan address, still blanked
// ST_DISPLAY | LEDs on for BASE_TICKS<<plane clocks, then next plane / row
module led_panel_bcm
   import led_panel_pkg::*;
#(
   parameter int COLS          = 8,
   parameter int ROW_ADDR_BITS = 2,
   parameter int BPC           = 2,
   parameter int BASE_TICKS    = 4,
   localparam int AW           = addr_width(ROW_ADDR_BITS, COLS),
   localparam int PW           = pix_width(BPC)
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
`ifdef LED_PANEL_TEST_PATTERN_EN
   input  logic                     i_mode,
`endif
   input  logic                     i_wr_en,
   input  logic [AW-1:0]            i_wr_addr,
   input  logic [PW-1:0]            i_wr_data,
   input  logic                     i_swap_req,
   output logic                     o_swap_done,
   output logic [1:0]               o_red_out,
   output logic [1:0]               o_green_out,
   output logic [1:0]               o_blue_out,
   output logic                     o_sclk_out,
   output logic                     o_latch_out,
   output logic                     o_blank_out,
   output logic [ROW_ADDR_BITS-1:0] o_addr_out
);

   localparam int CW   = $clog2(COLS);
   localparam int PLW  = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int TW   = $clog2((BASE_TICKS << (BPC - 1)) + 1);
   localparam int R_LO = red_lo(BPC);
   localparam int G_LO = green_lo(BPC);

   localparam logic [CW-1:0]  LAST_COL   = CW'(COLS - 1);
   localparam logic [PLW-1:0] LAST_PLANE = PLW'(BPC - 1);
   localparam logic [TW-1:0]  BASE_T     = TW'(BASE_TICKS);

   state_t                   r_state;
   logic [CW-1:0]            r_col;
   logic [PLW-1:0]           r_plane;
   logic [ROW_ADDR_BITS-1:0] r_row;
   logic [TW-1:0]            r_ticks;
   logic                     r_front;
   logic                     r_pending;
   logic                     r_sclk;
   logic                     r_latch;
   logic                     r_blank;
   logic [ROW_ADDR_BITS-1:0] r_addr;

   logic [PW-1:0]  w_upper;
   logic [PW-1:0]  w_lower;
   logic [BPC-1:0] w_up_r, w_up_g, w_up_b;
   logic [BPC-1:0] w_lo_r, w_lo_g, w_lo_b;
   logic           w_frame_end;
   logic           w_swap;

   led_panel_fb #(
      .COLS          (COLS),
      .ROW_ADDR_BITS (ROW_ADDR_BITS),
      .BPC           (BPC)
   ) u_fb (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_front   (r_front),
      .i_rd_row  (r_row),
      .i_rd_col  (r_col),
      .o_upper   (w_upper),
      .o_lower   (w_lower)
   );

   assign w_up_r = w_upper[R_LO +: BPC];
   assign w_up_g = w_upper[G_LO +: BPC];
   assign w_up_b = w_upper[BLUE_LO +: BPC];
   assign w_lo_r = w_lower[R_LO +: BPC];
   assign w_lo_g = w_lower[G_LO +: BPC];
   assign w_lo_b = w_lower[BLUE_LO +: BPC];

   // A request arriving in the frame-end cycle itself still swaps this frame.
   assign w_frame_end = (r_state == ST_DISPLAY) && (r_ticks == '0) &&
                        (r_plane == LAST_PLANE) && (&r_row);
   assign w_swap      = w_frame_end && (r_pending || i_swap_req);
   assign o_swap_done = w_swap;

   // Column/plane/row stay put through LATCH and DISPLAY, so data is held.
   always_comb begin
      o_red_out   = {w_lo_r[r_plane], w_up_r[r_plane]};
      o_green_out = {w_lo_g[r_plane], w_up_g[r_plane]};
      o_blue_out  = {w_lo_b[r_plane], w_up_b[r_plane]};
`ifdef LED_PANEL_TEST_PATTERN_EN
      if (i_mode) begin
         o_red_out   = {2{r_col[0]}};
         o_green_out = {2{r_row[0]}};
         o_blue_out  = {2{r_plane[0]}};
      end
`endif
   end

   assign o_sclk_out  = r_sclk;
   assign o_latch_out = r_latch;
   assign o_blank_out = r_blank;
   assign o_addr_out  = r_addr;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_SHIFT;
         r_col     <= '0;
         r_plane   <= '0;
         r_row     <= '0;
         r_ticks   <= '0;
         r_front   <= 1'b0;
         r_pending <= 1'b0;
         r_sclk    <= 1'b0;
         r_latch   <= 1'b0;
         r_blank   <= 1'b1;
         r_addr    <= '0;
      end else begin
         if (w_swap) begin
            r_front   <= !r_front;
            r_pending <= 1'b0;
         end else if (i_swap_req) begin
            r_pending <= 1'b1;
         end

         case (r_state)
            ST_SHIFT: begin
               // r_sclk doubles as the column phase bit
               r_sclk <= !r_sclk;
               if (r_sclk) begin
                  if (r_col == LAST_COL) begin
                     r_state <= ST_LATCH;
                     r_latch <= 1'b1;
                     r_addr  <= r_row;
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            ST_LATCH: begin
               r_state <= ST_DISPLAY;
               r_latch <= 1'b0;
               r_blank <= 1'b0;
               r_ticks <= (BASE_T << r_plane) - TW'(1);
            end
            ST_DISPLAY: begin
               if (r_ticks == '0) begin
                  r_state <= ST_SHIFT;
                  r_blank <= 1'b1;
                  r_col   <= '0;
                  if (r_plane == LAST_PLANE) begin
                     r_plane <= '0;
                     r_row   <= r_row + ROW_ADDR_BITS'(1);
                  end else begin
                     r_plane <= r_plane + PLW'(1);
                  end
               end else begin
                  r_ticks <= r_ticks - TW'(1);
               end
            end
            default: r_state <= ST_SHIFT;
         endcase
      end
   end

endmodule
